// File: rtl/if_fetch_buf_pkg.sv
// if_fetch_buf_pkg: shared constants and types for the instruction fetch buffer.
// Holds bus widths, enable/reset polarities, buffer depth and the {pc, inst} entry type.
// Optional feature macro used by the block: IF_FETCH_BUF_BYPASS_EN.
package if_fetch_buf_pkg;

  localparam int   INST_ADDR_W  = 32;
  localparam int   INST_W       = 32;
  localparam logic RST_ENABLE   = 1'b1;
  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic [INST_W-1:0] ZERO_WORD = '0;
  localparam int   IF_BUF_DEPTH = 4;
  localparam int   IF_BUF_PTR_W = 2;

  typedef logic [IF_BUF_PTR_W-1:0] buf_ptr_t;
  typedef logic [IF_BUF_PTR_W:0]   buf_cnt_t;  // 0..IF_BUF_DEPTH

  typedef struct packed {
    logic [INST_ADDR_W-1:0] pc;
    logic [INST_W-1:0]      inst;
  } fetch_ent_t;

endpackage

// File: rtl/if_fetch_buf_if.sv
// if_fetch_buf_if: PC-stage, instruction-memory and decode-stage signals of the fetch buffer.
// slave modport: the fetch buffer; master modport: the surrounding pipeline / memory.
// Signals: pc, ce, flush, if_stall, inst_mem_addr/ce/rdata, id_valid/pc/inst, id_ready.
interface if_fetch_buf_if;
  import if_fetch_buf_pkg::*;

  logic [INST_ADDR_W-1:0] pc;
  logic                   ce;
  logic                   flush;
  logic                   if_stall;
  logic [INST_ADDR_W-1:0] inst_mem_addr;
  logic                   inst_mem_ce;
  logic [INST_W-1:0]      inst_mem_rdata;
  logic                   id_valid;
  logic [INST_ADDR_W-1:0] id_pc;
  logic [INST_W-1:0]      id_inst;
  logic                   id_ready;

  modport slave (
    input  pc, ce, flush, inst_mem_rdata, id_ready,
    output if_stall, inst_mem_addr, inst_mem_ce, id_valid, id_pc, id_inst
  );

  modport master (
    output pc, ce, flush, inst_mem_rdata, id_ready,
    input  if_stall, inst_mem_addr, inst_mem_ce, id_valid, id_pc, id_inst
  );

endinterface

// File: rtl/if_buf_fifo.sv
// if_buf_fifo: 4-entry FIFO of fetched {pc, inst} pairs with flush.
// Ports: clk, rst, push_i/pop_i/flush_i, wr_dat_i in; rd_dat_o (head, zero when empty),
// full_o, empty_o, count_o out. Push when full and pop when empty are ignored.
module if_buf_fifo
  import if_fetch_buf_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic       flush_i,
  input  fetch_ent_t wr_dat_i,
  output fetch_ent_t rd_dat_o,
  output logic       full_o,
  output logic       empty_o,
  output buf_cnt_t   count_o
);

  fetch_ent_t mem_q [IF_BUF_DEPTH];
  buf_ptr_t   wr_ptr_q, wr_ptr_d;
  buf_ptr_t   rd_ptr_q, rd_ptr_d;
  buf_cnt_t   count_q, count_d;
  logic       do_push, do_pop;

  assign full_o   = (count_q == buf_cnt_t'(IF_BUF_DEPTH));
  assign empty_o  = (count_q == '0);
  assign count_o  = count_q;
  assign do_push  = push_i && !full_o && !flush_i;
  assign do_pop   = pop_i && !empty_o && !flush_i;
  assign rd_dat_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers are exactly log2(depth) wide, so the increment wraps 3 -> 0.
      if (do_push) wr_ptr_d = wr_ptr_q + buf_ptr_t'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + buf_ptr_t'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + buf_cnt_t'(1);
        2'b01:   count_d = count_q - buf_cnt_t'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < IF_BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) begin
        mem_q[wr_ptr_q] <= wr_dat_i;
      end
    end
  end

endmodule

// File: rtl/if_fetch_buf.sv
// if_fetch_buf: decouples the PC stage from decode with a 4-deep buffer of fetched instructions.
// Ports: clk, rst (sync, active high) and bus (if_fetch_buf_if.slave). Requests are accepted
// only while buffered + in-flight < 4, so every one-cycle memory return always has room.
// Latency: pc accepted in N -> id_valid in N+2 (N+1 when IF_FETCH_BUF_BYPASS_EN is defined,
// which lets a return into an empty buffer be presented to decode in the same cycle).
module if_fetch_buf
  import if_fetch_buf_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  if_fetch_buf_if.slave  bus
);

  logic                   rst_act;
  logic                   ce_en;
  logic                   accept;
  logic [3:0]             outstanding;
  logic                   inflight_q, inflight_d;
  logic [INST_ADDR_W-1:0] req_pc_q, req_pc_d;
  logic                   ret_vld;
  fetch_ent_t             ret_ent;
  fetch_ent_t             head_ent;
  fetch_ent_t             out_ent;
  logic                   out_vld;
  logic                   fifo_push, fifo_pop;
  logic                   fifo_full, fifo_empty;
  buf_cnt_t               fifo_cnt;

  assign rst_act = (rst == RST_ENABLE);
  assign ce_en   = (bus.ce == CHIP_ENABLE);

  // Reserve a slot for the in-flight word at request time.
  assign outstanding = {1'b0, fifo_cnt} + 4'(inflight_q);
  assign accept      = !rst_act && ce_en && !bus.flush && (outstanding < 4'(IF_BUF_DEPTH));

  assign bus.inst_mem_addr = bus.pc;
  assign bus.inst_mem_ce   = accept;
  assign bus.if_stall      = !rst_act && ce_en && !accept;

  // Returning data is dropped in flush and reset cycles.
  assign ret_vld = inflight_q && !bus.flush && !rst_act;
  assign ret_ent = '{pc: req_pc_q, inst: bus.inst_mem_rdata};

`ifdef IF_FETCH_BUF_BYPASS_EN
  logic byp_vld;
  assign byp_vld   = ret_vld && fifo_empty;
  assign out_vld   = !fifo_empty || byp_vld;
  assign out_ent   = byp_vld ? ret_ent : head_ent;
  // A bypassed word taken by decode this cycle never enters the buffer.
  assign fifo_push = ret_vld && !fifo_full && !(byp_vld && bus.id_ready);
`else
  assign out_vld   = !fifo_empty;
  assign out_ent   = head_ent;
  assign fifo_push = ret_vld && !fifo_full;
`endif

  assign fifo_pop = !fifo_empty && bus.id_ready && !rst_act;

  assign bus.id_valid = !rst_act && out_vld;
  assign bus.id_pc    = bus.id_valid ? out_ent.pc   : ZERO_WORD;
  assign bus.id_inst  = bus.id_valid ? out_ent.inst : ZERO_WORD;

  always_comb begin
    inflight_d = accept;
    req_pc_d   = accept ? bus.pc : req_pc_q;
  end

  always_ff @(posedge clk) begin
    if (rst_act) begin
      inflight_q <= 1'b0;
      req_pc_q   <= '0;
    end else begin
      inflight_q <= inflight_d;
      req_pc_q   <= req_pc_d;
    end
  end

  if_buf_fifo u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_i   (fifo_push),
    .pop_i    (fifo_pop),
    .flush_i  (bus.flush),
    .wr_dat_i (ret_ent),
    .rd_dat_o (head_ent),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty),
    .count_o  (fifo_cnt)
  );

endmodule
